// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind a single-outstanding
// valid/ready request/response pair. Define DMEM_ERR_EN to enable error checks.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state;
  state_t      nxt;
  logic [3:0]  cnt;
  req_t        cap;
  req_t        acc;
  logic        enter;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] word;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic        is_b;
  logic        is_h;
  logic        uns;
  logic        rsv;
  logic        err;
  logic [31:0] ld;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        unused_ok;

  // With zero wait states the access happens on the accepting edge,
  // so the live request is used; otherwise the captured copy.
  assign acc = (state == S_IDLE)
             ? {req_we, req_ctrl, req_addr, req_wdata}
             : cap;

  assign enter = (nxt == S_RESP) && (state != S_RESP);
  assign idx   = acc.addr[2 +: AW];
  assign word  = mem[idx];
  assign is_b  = (acc.ctrl[1:0] == 2'b00);
  assign is_h  = (acc.ctrl[1:0] == 2'b01);
  assign uns   = acc.ctrl[2];
  assign rsv   = (acc.ctrl == 3'b011) || (acc.ctrl[2:1] == 2'b11);

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  assign unused_ok = ^{rsv, acc.addr[31:AW+2]};

  // Access error decode; constant zero when checks are disabled.
  always_comb begin
    err = 1'b0;
`ifdef DMEM_ERR_EN
    err = rsv
        | (is_h & acc.addr[0])
        | (!is_b & !is_h & (acc.addr[1:0] != 2'b00))
        | (acc.addr >= 32'(4 * DEPTH_WORDS));
`endif
  end

  // Next-state logic for the single-outstanding handshake.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    bsel = word[{acc.addr[1:0], 3'b000} +: 8];
    hsel = acc.addr[1] ? word[31:16] : word[15:0];
    ld   = word;
    unique case (1'b1)
      is_b:    ld = uns ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
      is_h:    ld = uns ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
      default: ld = word;
    endcase
  end

  // Store lane enables with data replicated across lanes.
  always_comb begin
    be = 4'hf;
    wd = acc.wdata;
    unique case (1'b1)
      is_b: begin
        be = 4'b0001 << acc.addr[1:0];
        wd = {4{acc.wdata[7:0]}};
      end
      is_h: begin
        be = acc.addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{acc.wdata[15:0]}};
      end
      default: begin
        be = 4'hf;
        wd = acc.wdata;
      end
    endcase
  end

  // Array write on the edge entering RESP; contents are never reset.
  always_ff @(posedge CLK) begin
    if (enter && acc.we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // State, wait counter, captured request and response registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cap       <= '0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && req_valid) begin
        cap <= {req_we, req_ctrl, req_addr, req_wdata};
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter) begin
        rsp_rdata <= (acc.we || err) ? 32'd0 : ld;
        rsp_err   <= err;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store vectors with immediate assertions
// covering latency, lane handling, backpressure, errors and mid-op reset.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vecs;
  int miscompares;

  logic [31:0] rd;
  logic        er;
  int          lat;

  localparam logic [2:0] C_B  = 3'b000;
  localparam logic [2:0] C_H  = 3'b001;
  localparam logic [2:0] C_W  = 3'b010;
  localparam logic [2:0] C_BU = 3'b100;
  localparam logic [2:0] C_HU = 3'b101;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(1)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_ctrl  (req_ctrl),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; leaves the bench at posedge+1 in IDLE.
  task automatic xact(input logic we,
                      input logic [2:0] ctrl,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      output logic [31:0] o_rd,
                      output logic o_err,
                      output int o_lat);
    check("req_ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_ctrl  = 3'b111;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = 32'h5555_AAAA;
    o_lat = 1;
    while (!rsp_valid && o_lat < 20) begin
      @(posedge clk);
      #1;
      o_lat++;
    end
    o_rd  = rsp_rdata;
    o_err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    vecs        = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_ctrl    = 3'b000;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    rsp_ready   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);

    xact(1'b1, C_W, 32'h10, 32'h8000_00FF, rd, er, lat);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_rdata", rd, 32'd0);
    check("sw_err", {31'b0, er}, 32'd0);
    check("idle_after_sw", {31'b0, req_ready}, 32'd1);

    xact(1'b0, C_W, 32'h10, 32'h0, rd, er, lat);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", rd, 32'h8000_00FF);
    check("lw_err", {31'b0, er}, 32'd0);

    xact(1'b0, C_B, 32'h10, 32'h0, rd, er, lat);
    check("lb_10", rd, 32'hFFFF_FFFF);
    xact(1'b0, C_BU, 32'h13, 32'h0, rd, er, lat);
    check("lbu_13", rd, 32'h0000_0080);
    xact(1'b0, C_H, 32'h12, 32'h0, rd, er, lat);
    check("lh_12", rd, 32'hFFFF_8000);
    xact(1'b0, C_HU, 32'h10, 32'h0, rd, er, lat);
    check("lhu_10", rd, 32'h0000_00FF);

    xact(1'b1, C_W, 32'h14, 32'h1122_3344, rd, er, lat);
    xact(1'b1, C_B, 32'h11, 32'h1234_565A, rd, er, lat);
    xact(1'b0, C_W, 32'h10, 32'h0, rd, er, lat);
    check("sb_merge", rd, 32'h8000_5AFF);
    xact(1'b0, C_W, 32'h14, 32'h0, rd, er, lat);
    check("neighbour_word", rd, 32'h1122_3344);
    xact(1'b1, C_H, 32'h16, 32'hCAFE_BEEF, rd, er, lat);
    xact(1'b0, C_W, 32'h14, 32'h0, rd, er, lat);
    check("sh_upper", rd, 32'hBEEF_3344);

    req_valid = 1'b1;
    req_we    = 1'b0;
    req_ctrl  = C_W;
    req_addr  = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("hold_lat", 32'(lat), 32'd2);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_ctrl  = C_W;
    req_addr  = 32'h10;
    req_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, 32'h8000_5AFF);
      check("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("pulse_valid", {31'b0, rsp_valid}, 32'd0);
    check("pulse_ready", {31'b0, req_ready}, 32'd1);
    xact(1'b0, C_W, 32'h10, 32'h0, rd, er, lat);
    check("hold_no_store", rd, 32'h8000_5AFF);

`ifdef DMEM_ERR_EN
    xact(1'b0, C_W, 32'h12, 32'h0, rd, er, lat);
    check("err_lw_err", {31'b0, er}, 32'd1);
    check("err_lw_rdata", rd, 32'd0);
    check("err_lw_lat", 32'(lat), 32'd2);
    xact(1'b1, C_W, 32'h12, 32'hFFFF_FFFF, rd, er, lat);
    check("err_sw_err", {31'b0, er}, 32'd1);
    xact(1'b0, C_W, 32'h10, 32'h0, rd, er, lat);
    check("err_sw_kept", rd, 32'h8000_5AFF);
    xact(1'b0, C_W, 32'h1010, 32'h0, rd, er, lat);
    check("err_range", {31'b0, er}, 32'd1);
    xact(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    check("err_rsv", {31'b0, er}, 32'd1);
`else
    xact(1'b0, C_W, 32'h12, 32'h0, rd, er, lat);
    check("mis_lw_rdata", rd, 32'h8000_5AFF);
    check("mis_lw_err", {31'b0, er}, 32'd0);
    xact(1'b0, C_W, 32'h1010, 32'h0, rd, er, lat);
    check("wrap_lw", rd, 32'h8000_5AFF);
    xact(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    check("rsv_as_w", rd, 32'h8000_5AFF);
`endif

    xact(1'b1, C_W, 32'h20, 32'h00C0_FFEE, rd, er, lat);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_ctrl  = C_W;
    req_addr  = 32'h20;
    req_wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("mid_in_wait", {31'b0, req_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    xact(1'b0, C_W, 32'h20, 32'h0, rd, er, lat);
    check("mid_rst_kept", rd, 32'h00C0_FFEE);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
